debounce_multi: RTL and testbench



---
 rtl/debounce_multi.sv | 99 +++++++++
 tb/tb_debounce_multi.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: synchronises, filters and edge-detects each
// button independently, with an optional one-shot long-press strobe per channel.
module debounce_multi #(
    parameter int unsigned CLK_FREQ       = 50000000,
    parameter int unsigned STABLE_TIME_MS = 10,
    parameter int unsigned HOLD_TIME_MS   = 1000,
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] result,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] held
);
    localparam int unsigned STABLE_CYCLES = CLK_FREQ / 1000 * STABLE_TIME_MS;
    localparam int unsigned HOLD_CYCLES   = CLK_FREQ / 1000 * HOLD_TIME_MS;
    localparam int unsigned CNT_W         = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned HCNT_W        = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [CNT_W-1:0]       cnt;
        logic                   level;
        logic                   rise_q;
        logic                   fall_q;
        logic                   s_c;
        logic                   flip_c;

        assign s_c    = sync[SYNC_STAGES-1];
        assign flip_c = (s_c != level) && (cnt == CNT_W'(STABLE_CYCLES - 1));

        // Synchroniser, stability filter and press/release strobes
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync   <= '0;
                cnt    <= '0;
                level  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync   <= {sync[SYNC_STAGES-2:0], button[i]};
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s_c == level) begin
                    cnt <= '0;
                end else if (flip_c) begin
                    level  <= s_c;
                    cnt    <= '0;
                    rise_q <= s_c;
                    fall_q <= ~s_c;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        if (HOLD_CYCLES > 0) begin : g_hold
            logic [HCNT_W-1:0] hcnt;
            logic              armed;
            logic              held_q;

            // One-shot long-press detector; re-arms only once the button is released
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hcnt   <= '0;
                    armed  <= 1'b1;
                    held_q <= 1'b0;
                end else begin
                    held_q <= 1'b0;
                    if (!level) begin
                        hcnt  <= '0;
                        armed <= 1'b1;
                    end else if (armed) begin
                        if (hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
                            hcnt   <= HCNT_W'(HOLD_CYCLES);
                            armed  <= 1'b0;
                            // a release landing on the same edge wins, keeping held and fall apart
                            held_q <= ~flip_c;
                        end else begin
                            hcnt <= hcnt + HCNT_W'(1);
                        end
                    end
                end
            end

            assign held[i] = held_q;
        end else begin : g_no_hold
            assign held[i] = 1'b0;
        end

        assign result[i] = level;
        assign rise[i]   = rise_q;
        assign fall[i]   = fall_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random soak, checked against
// a run-length reference model of the synchronised, filtered button levels.
`timescale 1ns/1ps
module tb_debounce_multi;
    localparam int CH     = 4;
    localparam int SYNC   = 2;
    localparam int STABLE = 1000;
    localparam int HOLD   = 5000;
    localparam int LAT    = SYNC + STABLE - 1;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic [CH-1:0] button = '0;
    logic [CH-1:0] result, rise, fall, held;

    debounce_multi #(
        .CLK_FREQ(1000000), .STABLE_TIME_MS(1), .HOLD_TIME_MS(5),
        .CHANNELS(CH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .button(button),
        .result(result), .rise(rise), .fall(fall), .held(held)
    );

    always #500 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Reference model state
    logic          sh [CH][SYNC];
    logic          run_lvl [CH];
    int            run_len [CH];
    int            hi_len [CH];
    logic [CH-1:0] m_res = '0, m_rise = '0, m_fall = '0, m_held = '0;
    int            m_rise_tot [CH], m_held_tot [CH];
    logic          mdl_s;

    // Observed DUT events
    int          d_rise_cnt [CH], d_fall_cnt [CH], d_held_cnt [CH];
    int          d_rise_edge [CH], d_fall_edge [CH], d_held_edge [CH];
    int          cyc_mism = 0, overlap = 0, strobe_in_reset = 0, mm_edge = 0;
    logic [15:0] mm_act = '0, mm_exp = '0;

    // Model: result follows the delayed input once it has run STABLE samples at a new level
    initial begin
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < SYNC; k++) sh[c][k] = 1'b0;
            run_lvl[c] = 1'b0; run_len[c] = 0; hi_len[c] = 0;
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int c = 0; c < CH; c++) begin
                    for (int k = 0; k < SYNC; k++) sh[c][k] = 1'b0;
                    run_lvl[c] = 1'b0; run_len[c] = 0; hi_len[c] = 0;
                end
                m_res = '0; m_rise = '0; m_fall = '0; m_held = '0;
            end else begin
                for (int c = 0; c < CH; c++) begin
                    mdl_s = sh[c][SYNC-1];
                    for (int k = SYNC - 1; k > 0; k--) sh[c][k] = sh[c][k-1];
                    sh[c][0] = button[c];
                    if (mdl_s == run_lvl[c]) run_len[c]++;
                    else begin run_lvl[c] = mdl_s; run_len[c] = 1; end
                    m_rise[c] = 1'b0; m_fall[c] = 1'b0;
                    if (run_lvl[c] != m_res[c] && run_len[c] >= STABLE) begin
                        m_res[c]  = run_lvl[c];
                        m_rise[c] = run_lvl[c];
                        m_fall[c] = ~run_lvl[c];
                        hi_len[c] = 0;
                        if (run_lvl[c]) m_rise_tot[c]++;
                    end else if (m_res[c]) begin
                        hi_len[c]++;
                    end
                    m_held[c] = m_res[c] && (hi_len[c] == HOLD);
                    if (m_held[c]) m_held_tot[c]++;
                end
            end
        end
    end

    // Monitor: sample away from the edge, log events and model disagreement
    initial begin
        forever begin
            @(posedge clk);
            #200;
            for (int c = 0; c < CH; c++) begin
                if (rise[c] === 1'b1) begin d_rise_cnt[c]++; d_rise_edge[c] = edge_no; end
                if (fall[c] === 1'b1) begin d_fall_cnt[c]++; d_fall_edge[c] = edge_no; end
                if (held[c] === 1'b1) begin d_held_cnt[c]++; d_held_edge[c] = edge_no; end
            end
            if ({result, rise, fall, held} !== {m_res, m_rise, m_fall, m_held}) begin
                if (cyc_mism == 0) begin
                    mm_edge = edge_no;
                    mm_act  = {result, rise, fall, held};
                    mm_exp  = {m_res, m_rise, m_fall, m_held};
                end
                cyc_mism++;
            end
            if (((rise & fall) | (rise & held) | (fall & held)) != '0) overlap++;
            if (reset && ((rise | fall | held) != '0)) strobe_in_reset++;
        end
    end

    initial begin
        #120ms;
        $display("FAIL watchdog: simulation did not finish within 120 ms");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        for (int c = 0; c < CH; c++) begin
            d_rise_cnt[c] = 0; d_fall_cnt[c] = 0; d_held_cnt[c] = 0;
            d_rise_edge[c] = 0; d_fall_edge[c] = 0; d_held_edge[c] = 0;
            m_rise_tot[c] = 0; m_held_tot[c] = 0;
        end
        cyc_mism = 0; overlap = 0; strobe_in_reset = 0;
    endtask

    task automatic apply_reset(input logic [CH-1:0] btn);
        @(negedge clk);
        reset = 1'b1;
        button = btn;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int e0;
        @(negedge clk);
        reset = 1'b1;
        button = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({result, rise, fall, held} !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0000", {result, rise, fall, held});
            end
        end
        clear_stats();
        reset = 1'b0;
        e0 = edge_no + 1;
        repeat (LAT + 100) @(negedge clk);
        checks++;
        if (result !== 4'hF) begin
            errors++; $display("FAIL reset_result: got %h expected f", result);
        end
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (d_rise_edge[c] !== e0 + LAT) begin
                errors++; $display("FAIL reset_rise_edge ch%0d: got %0d expected %0d", c, d_rise_edge[c], e0 + LAT);
            end
            checks++;
            if (d_rise_cnt[c] !== 1) begin
                errors++; $display("FAIL reset_rise_width ch%0d: got %0d expected 1", c, d_rise_cnt[c]);
            end
        end
        checks++;
        if (cyc_mism !== 0) begin
            errors++; $display("FAIL reset_model: %0d cycles, first edge %0d got %h expected %h", cyc_mism, mm_edge, mm_act, mm_exp);
        end
    endtask

    task automatic test_press_bounce();
        int e_fin;
        apply_reset(4'h0);
        clear_stats();
        for (int k = 0; k < 8; k++) begin
            button[0] = (k % 2 == 0);
            repeat (100) @(negedge clk);
        end
        button[0] = 1'b1;
        e_fin = edge_no + 1;
        repeat (LAT + 200) @(negedge clk);
        checks++;
        if (d_rise_edge[0] !== e_fin + LAT) begin
            errors++; $display("FAIL bounce_rise_edge: got %0d expected %0d", d_rise_edge[0], e_fin + LAT);
        end
        checks++;
        if (d_rise_cnt[0] !== 1 || d_fall_cnt[0] !== 0) begin
            errors++; $display("FAIL bounce_pulses: rise %0d fall %0d expected 1 and 0", d_rise_cnt[0], d_fall_cnt[0]);
        end
        checks++;
        if (cyc_mism !== 0) begin
            errors++; $display("FAIL bounce_model: %0d cycles, first edge %0d got %h expected %h", cyc_mism, mm_edge, mm_act, mm_exp);
        end
    endtask

    task automatic test_release_bounce();
        int e_fin;
        apply_reset(4'h0);
        button[1] = 1'b1;
        repeat (LAT + 100) @(negedge clk);
        checks++;
        if (result[1] !== 1'b1) begin
            errors++; $display("FAIL release_setup: got %b expected 1", result[1]);
        end
        clear_stats();
        for (int k = 0; k < 6; k++) begin
            button[1] = (k % 2 == 1);
            repeat (200) @(negedge clk);
        end
        button[1] = 1'b0;
        e_fin = edge_no + 1;
        repeat (LAT + 200) @(negedge clk);
        checks++;
        if (d_fall_edge[1] !== e_fin + LAT) begin
            errors++; $display("FAIL release_fall_edge: got %0d expected %0d", d_fall_edge[1], e_fin + LAT);
        end
        checks++;
        if (d_fall_cnt[1] !== 1 || d_rise_cnt[1] !== 0) begin
            errors++; $display("FAIL release_pulses: fall %0d rise %0d expected 1 and 0", d_fall_cnt[1], d_rise_cnt[1]);
        end
        checks++;
        if (cyc_mism !== 0) begin
            errors++; $display("FAIL release_model: %0d cycles, first edge %0d got %h expected %h", cyc_mism, mm_edge, mm_act, mm_exp);
        end
    endtask

    task automatic test_glitch();
        int e_s;
        apply_reset(4'h0);
        clear_stats();
        button[2] = 1'b1;
        repeat (998) @(negedge clk);
        button[2] = 1'b0;
        repeat (LAT + 200) @(negedge clk);
        checks++;
        if (result[2] !== 1'b0 || d_rise_cnt[2] !== 0 || d_fall_cnt[2] !== 0) begin
            errors++; $display("FAIL glitch_998: result %b rise %0d fall %0d expected 0 0 0", result[2], d_rise_cnt[2], d_fall_cnt[2]);
        end
        button[2] = 1'b1;
        repeat (999) @(negedge clk);
        button[2] = 1'b0;
        repeat (LAT + 200) @(negedge clk);
        clear_stats();
        button[2] = 1'b1;
        e_s = edge_no + 1;
        repeat (STABLE) @(negedge clk);
        button[2] = 1'b0;
        repeat (LAT + 200) @(negedge clk);
        checks++;
        if (d_rise_cnt[2] !== 1 || d_rise_edge[2] !== e_s + LAT) begin
            errors++; $display("FAIL glitch_threshold: rise %0d at %0d expected 1 at %0d", d_rise_cnt[2], d_rise_edge[2], e_s + LAT);
        end
        checks++;
        if (cyc_mism !== 0) begin
            errors++; $display("FAIL glitch_model: %0d cycles, first edge %0d got %h expected %h", cyc_mism, mm_edge, mm_act, mm_exp);
        end
    endtask

    task automatic test_long_press();
        int e_s, e_r;
        int lens [3] = '{4000, 4999, 5001};
        int exp_held [3] = '{0, 0, 1};
        apply_reset(4'h0);
        clear_stats();
        button[3] = 1'b1;
        e_s = edge_no + 1;
        repeat (7000) @(negedge clk);
        button[3] = 1'b0;
        repeat (LAT + 200) @(negedge clk);
        checks++;
        if (d_held_cnt[3] !== 1 || d_held_edge[3] !== e_s + LAT + HOLD) begin
            errors++; $display("FAIL long_held: count %0d at %0d expected 1 at %0d", d_held_cnt[3], d_held_edge[3], e_s + LAT + HOLD);
        end
        for (int j = 0; j < 3; j++) begin
            clear_stats();
            button[3] = 1'b1;
            e_s = edge_no + 1;
            repeat (lens[j]) @(negedge clk);
            button[3] = 1'b0;
            e_r = edge_no + 1;
            repeat (LAT + 200) @(negedge clk);
            checks++;
            if (d_fall_edge[3] - d_rise_edge[3] !== e_r - e_s) begin
                errors++; $display("FAIL press_len_%0d: high for %0d expected %0d", lens[j], d_fall_edge[3] - d_rise_edge[3], e_r - e_s);
            end
            checks++;
            if (d_held_cnt[3] !== exp_held[j]) begin
                errors++; $display("FAIL press_held_%0d: got %0d expected %0d", lens[j], d_held_cnt[3], exp_held[j]);
            end
            checks++;
            if (d_held_edge[3] !== (exp_held[j] != 0 ? e_s + LAT + HOLD : 0)) begin
                errors++; $display("FAIL press_held_edge_%0d: got %0d", lens[j], d_held_edge[3]);
            end
        end
        checks++;
        if (cyc_mism !== 0 || overlap !== 0) begin
            errors++; $display("FAIL long_model: %0d cycles, overlap %0d, first edge %0d got %h expected %h", cyc_mism, overlap, mm_edge, mm_act, mm_exp);
        end
    endtask

    task automatic test_independence();
        int chs [2] = '{0, 2};
        int togg [2] = '{5, 7};
        int rem [2];
        int fin [2] = '{0, 0};
        int e_s;
        apply_reset(4'h0);
        clear_stats();
        button[0] = 1'b1;
        button[2] = 1'b1;
        for (int j = 0; j < 2; j++) rem[j] = int'($urandom_range(30, 900));
        while (fin[0] == 0 || fin[1] == 0) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (fin[j] == 0) begin
                    rem[j]--;
                    if (rem[j] == 0) begin
                        if (togg[j] == 0) begin
                            button[chs[j]] = 1'b1;
                            fin[j] = edge_no + 1;
                        end else begin
                            button[chs[j]] = ~button[chs[j]];
                            togg[j]--;
                            rem[j] = int'($urandom_range(30, 900));
                        end
                    end
                end
            end
        end
        repeat (LAT + 200) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (d_rise_cnt[chs[j]] !== 1 || d_rise_edge[chs[j]] !== fin[j] + LAT) begin
                errors++; $display("FAIL indep_ch%0d: rise %0d at %0d expected 1 at %0d", chs[j], d_rise_cnt[chs[j]], d_rise_edge[chs[j]], fin[j] + LAT);
            end
        end
        checks++;
        if (cyc_mism !== 0) begin
            errors++; $display("FAIL indep_model: %0d cycles, first edge %0d got %h expected %h", cyc_mism, mm_edge, mm_act, mm_exp);
        end

        clear_stats();
        button = 4'b1010;
        repeat (500) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({result, rise, fall, held} !== 16'h0) begin
                errors++; $display("FAIL midreset_outputs: got %h expected 0000", {result, rise, fall, held});
            end
        end
        button = 4'h0;
        reset = 1'b0;
        repeat (LAT + 200) @(negedge clk);
        checks++;
        if (result !== 4'h0 || d_rise_cnt[1] !== 0 || d_rise_cnt[3] !== 0 || strobe_in_reset !== 0) begin
            errors++; $display("FAIL midreset_after: result %h rise1 %0d rise3 %0d strobes %0d expected all 0", result, d_rise_cnt[1], d_rise_cnt[3], strobe_in_reset);
        end

        clear_stats();
        button[3] = 1'b1;
        repeat (LAT + 3000) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        e_s = edge_no + 1;
        repeat (LAT + HOLD + 100) @(negedge clk);
        checks++;
        if (d_rise_edge[3] !== e_s + LAT) begin
            errors++; $display("FAIL hold_reset_rise: got %0d expected %0d", d_rise_edge[3], e_s + LAT);
        end
        checks++;
        if (d_held_cnt[3] !== 1 || d_held_edge[3] !== e_s + LAT + HOLD) begin
            errors++; $display("FAIL hold_reset_held: count %0d at %0d expected 1 at %0d", d_held_cnt[3], d_held_edge[3], e_s + LAT + HOLD);
        end
        checks++;
        if (cyc_mism !== 0 || strobe_in_reset !== 0) begin
            errors++; $display("FAIL midreset_model: %0d cycles, strobes %0d, first edge %0d got %h expected %h", cyc_mism, strobe_in_reset, mm_edge, mm_act, mm_exp);
        end
    endtask

    task automatic test_random();
        int rem [CH];
        apply_reset(4'h0);
        clear_stats();
        for (int c = 0; c < CH; c++) rem[c] = int'($urandom_range(1, 50));
        repeat (12000) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    button[c] = ~button[c];
                    rem[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1000, 6500))
                                                         : int'($urandom_range(1, 1100));
                end
            end
        end
        button = 4'h0;
        repeat (LAT + 200) @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (d_rise_cnt[c] !== m_rise_tot[c] || d_held_cnt[c] !== m_held_tot[c]) begin
                errors++; $display("FAIL random_counts ch%0d: rise %0d held %0d expected %0d %0d", c, d_rise_cnt[c], d_held_cnt[c], m_rise_tot[c], m_held_tot[c]);
            end
        end
        checks++;
        if (overlap !== 0) begin
            errors++; $display("FAIL random_overlap: got %0d expected 0", overlap);
        end
        checks++;
        if (cyc_mism !== 0) begin
            errors++; $display("FAIL random_model: %0d cycles, first edge %0d got %h expected %h", cyc_mism, mm_edge, mm_act, mm_exp);
        end
    endtask

    initial begin
        test_reset();
        test_press_bounce();
        test_release_bounce();
        test_glitch();
        test_long_press();
        test_independence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
